// File: rtl/pulse_window_gen.sv
// pulse_window_gen: per-channel trigger-to-pulse window generator.
// Each channel synchronizes an asynchronous trigger and detects the selected
// edge. On an event it waits a programmable delay, then drives a pulse for a
// programmable width. Delay/width are captured at the event so later input
// changes cannot disturb a running sequence.
module pulse_window_gen #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 21,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk1,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       trig,
    input  logic [CHANNELS-1:0]       edge_sel,
    input  logic                      retrig_en,
    input  logic [CHANNELS*CNT_W-1:0] delay,
    input  logic [CHANNELS*CNT_W-1:0] width,
    output logic [CHANNELS-1:0]       pulse,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   sync_out_s;
        logic                   event_s;
        logic [CNT_W-1:0]       new_dly_s;
        logic [CNT_W-1:0]       new_wid_s;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic [CNT_W-1:0]       dly_sh_q, dly_sh_d;
        logic [CNT_W-1:0]       wid_sh_q, wid_sh_d;
        logic                   ovr_q, ovr_d;
        logic                   pulse_q, busy_q, done_q;

        assign sync_out_s = sync_q[SYNC_STAGES-1];
        assign new_dly_s  = delay[g*CNT_W +: CNT_W];
        assign new_wid_s  = width[g*CNT_W +: CNT_W];

        // Edge detector: compares synchronized trigger against its history flop.
        always_comb begin
            if (edge_sel[g]) begin
                event_s = sync_out_s & ~prev_q;
            end else begin
                event_s = ~sync_out_s & prev_q;
            end
        end

        // Next-state logic: start/restart on events, otherwise count down.
        // A zero delay with zero width still spends one cycle in DELAY so the
        // channel reports busy for a cycle and then strobes done.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            dly_sh_d = dly_sh_q;
            wid_sh_d = wid_sh_q;
            ovr_d    = ovr_q;
            if (event_s && ((state_q == ST_IDLE) || retrig_en)) begin
                dly_sh_d = new_dly_s;
                wid_sh_d = new_wid_s;
                if ((new_dly_s == CNT_ZERO) && (new_wid_s != CNT_ZERO)) begin
                    state_d = ST_PULSE;
                    cnt_d   = new_wid_s;
                end else begin
                    state_d = ST_DELAY;
                    cnt_d   = new_dly_s;
                end
            end else begin
                // Reaching here with an event means the channel is busy and
                // restarts are disabled: record the lost event.
                if (event_s) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                case (state_q)
                    ST_IDLE: begin
                        cnt_d = cnt_q;
                    end
                    ST_DELAY: begin
                        if (cnt_q <= CNT_ONE) begin
                            if (wid_sh_q == CNT_ZERO) begin
                                state_d = ST_IDLE;
                                cnt_d   = CNT_ZERO;
                            end else begin
                                state_d = ST_PULSE;
                                cnt_d   = wid_sh_q;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q <= CNT_ONE) begin
                            state_d = ST_IDLE;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                endcase
            end
        end

        // State, counters, synchronizer and registered outputs.
        always_ff @(posedge clk1) begin
            if (!rst_n) begin
                sync_q   <= {SYNC_STAGES{1'b0}};
                prev_q   <= 1'b0;
                state_q  <= ST_IDLE;
                cnt_q    <= CNT_ZERO;
                dly_sh_q <= CNT_ZERO;
                wid_sh_q <= CNT_ZERO;
                ovr_q    <= 1'b0;
                pulse_q  <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                sync_q   <= {sync_q[SYNC_STAGES-2:0], trig[g]};
                prev_q   <= sync_out_s;
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                dly_sh_q <= dly_sh_d;
                wid_sh_q <= wid_sh_d;
                ovr_q    <= ovr_d;
                pulse_q  <= (state_d == ST_PULSE);
                busy_q   <= (state_d != ST_IDLE);
                done_q   <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
            end
        end

        assign pulse[g]   = pulse_q;
        assign busy[g]    = busy_q;
        assign done[g]    = done_q;
        assign overrun[g] = ovr_q;
    end

endmodule

// File: tb/tb_pulse_window_gen.sv
// Self-checking bench for pulse_window_gen (4 channels). Expected output
// windows are derived from trigger timing, delay and width, pushed to a
// scoreboard queue, and popped/compared one entry per clock.
module tb_pulse_window_gen;

    localparam int CH   = 4;
    localparam int CW   = 21;
    localparam int MAXE = 600;

    logic            clk1 = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   trig;
    logic [CH-1:0]   edge_sel;
    logic            retrig_en;
    logic [CH*CW-1:0] delay;
    logic [CH*CW-1:0] width;
    logic [CH-1:0]   pulse, busy, done, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] sb[$];
    logic [CH-1:0] xp[MAXE];
    logic [CH-1:0] xb[MAXE];
    logic [CH-1:0] xd[MAXE];
    logic [CH-1:0] xo[MAXE];

    pulse_window_gen #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk1(clk1), .rst_n(rst_n), .trig(trig), .edge_sel(edge_sel),
        .retrig_en(retrig_en), .delay(delay), .width(width),
        .pulse(pulse), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk1 = ~clk1;

    task automatic clear_exp();
        for (int e = 0; e < MAXE; e++) begin
            xp[e] = '0; xb[e] = '0; xd[e] = '0; xo[e] = '0;
        end
    endtask

    // Window for a trigger first sampled at edge t: busy from t+2 for
    // max(d+w,1) cycles, pulse from t+2+d for w cycles, done right after.
    // Entries at or after 'cut' are not written (sequence aborted there).
    task automatic add_win(int ch, int t, int d, int w, int cut);
        int s, bl;
        s  = t + 2;
        bl = (d + w > 0) ? d + w : 1;
        for (int e = 0; e < MAXE; e++) begin
            if (cut < 0 || e < cut) begin
                if (e >= s && e < s + bl) xb[e][ch] = 1'b1;
                if (e >= s + d && e < s + d + w) xp[e][ch] = 1'b1;
                if (e == s + bl) xd[e][ch] = 1'b1;
            end
        end
    endtask

    task automatic add_ovr(int ch, int from);
        for (int e = from; e < MAXE; e++) xo[e][ch] = 1'b1;
    endtask

    task automatic push_exp(int n);
        for (int e = 0; e < n; e++) sb.push_back({xp[e], xb[e], xd[e], xo[e]});
    endtask

    task automatic set_dw(int ch, int d, int w);
        delay[ch*CW +: CW] = CW'(d);
        width[ch*CW +: CW] = CW'(w);
    endtask

    task automatic do_reset(logic [CH-1:0] tv, logic [CH-1:0] es, int idle);
        trig = tv; edge_sel = es; rst_n = 1'b0;
        @(posedge clk1); #1;
        rst_n = 1'b1;
        repeat (idle) begin @(posedge clk1); #1; end
    endtask

    task automatic test_reset();
        logic [15:0] got;
        retrig_en = 1'b0; delay = '0; width = '0;
        trig = '0; edge_sel = '1; rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk1); #1;
            got = {pulse, busy, done, overrun};
            n_cmp++;
            if (got !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset cyc=%0d got=%h exp=0000", i, got);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_long();
        logic [15:0] got, ex;
        retrig_en = 1'b0; delay = '0; width = '0;
        do_reset(4'b0000, 4'b1111, 3);
        set_dw(0, 401, 79);
        clear_exp(); add_win(0, 0, 401, 79, -1); push_exp(490);
        for (int e = 0; e < 490; e++) begin
            if (e == 0) trig[0] = 1'b1;
            if (e == 10) set_dw(0, 7, 7);
            @(posedge clk1); #1;
            got = {pulse, busy, done, overrun};
            ex = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL long e=%0d got p/b/d/o=%h exp=%h", e, got, ex);
            end
        end
    endtask

    task automatic test_zero();
        logic [15:0] got, ex;
        retrig_en = 1'b0;
        do_reset(4'b0000, 4'b1111, 3);
        set_dw(0, 0, 0); set_dw(1, 0, 1); set_dw(2, 5, 0); set_dw(3, 1, 1);
        clear_exp();
        add_win(0, 0, 0, 0, -1); add_win(1, 0, 0, 1, -1);
        add_win(2, 0, 5, 0, -1); add_win(3, 0, 1, 1, -1);
        push_exp(12);
        for (int e = 0; e < 12; e++) begin
            if (e == 0) trig = 4'b1111;
            @(posedge clk1); #1;
            got = {pulse, busy, done, overrun};
            ex = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL zero e=%0d got p/b/d/o=%h exp=%h", e, got, ex);
            end
        end
    endtask

    task automatic test_multi();
        logic [15:0] got, ex;
        retrig_en = 1'b0;
        do_reset(4'b1000, 4'b0101, 4);
        set_dw(0, 4, 3); set_dw(1, 1, 5); set_dw(2, 0, 2); set_dw(3, 6, 1);
        clear_exp();
        add_win(0, 0, 4, 3, -1); add_win(1, 2, 1, 5, -1);
        add_win(2, 5, 0, 2, -1); add_win(3, 7, 6, 1, -1);
        push_exp(20);
        for (int e = 0; e < 20; e++) begin
            if (e == 0) begin trig[0] = 1'b1; trig[1] = 1'b1; end
            if (e == 2) trig[1] = 1'b0;
            if (e == 3) trig[0] = 1'b0;
            if (e == 5) trig[2] = 1'b1;
            if (e == 7) trig[3] = 1'b0;
            @(posedge clk1); #1;
            got = {pulse, busy, done, overrun};
            ex = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL multi e=%0d got p/b/d/o=%h exp=%h", e, got, ex);
            end
        end
    endtask

    task automatic test_retrig();
        logic [15:0] got, ex;
        retrig_en = 1'b1;
        do_reset(4'b0000, 4'b1111, 3);
        set_dw(0, 2, 6); set_dw(1, 0, 3); set_dw(2, 0, 0); set_dw(3, 0, 0);
        clear_exp();
        add_win(0, 0, 2, 6, 8); add_win(0, 6, 3, 2, -1);
        add_win(1, 0, 0, 3, 5); add_win(1, 3, 0, 3, -1);
        push_exp(16);
        for (int e = 0; e < 16; e++) begin
            if (e == 0) begin trig[0] = 1'b1; trig[1] = 1'b1; end
            if (e == 1) trig[1] = 1'b0;
            if (e == 3) begin trig[0] = 1'b0; trig[1] = 1'b1; end
            if (e == 6) begin trig[0] = 1'b1; set_dw(0, 3, 2); end
            @(posedge clk1); #1;
            got = {pulse, busy, done, overrun};
            ex = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL retrig e=%0d got p/b/d/o=%h exp=%h", e, got, ex);
            end
        end
    endtask

    task automatic test_overrun();
        logic [15:0] got, ex;
        retrig_en = 1'b0;
        do_reset(4'b0000, 4'b1111, 3);
        set_dw(0, 2, 6); set_dw(1, 0, 3); set_dw(2, 0, 0); set_dw(3, 0, 0);
        clear_exp();
        add_win(0, 0, 2, 6, -1); add_ovr(0, 8);
        add_win(1, 0, 0, 3, -1); add_ovr(1, 5);
        push_exp(16);
        for (int e = 0; e < 16; e++) begin
            if (e == 0) begin trig[0] = 1'b1; trig[1] = 1'b1; end
            if (e == 1) trig[1] = 1'b0;
            if (e == 3) begin trig[0] = 1'b0; trig[1] = 1'b1; end
            if (e == 6) begin trig[0] = 1'b1; set_dw(0, 3, 2); end
            @(posedge clk1); #1;
            got = {pulse, busy, done, overrun};
            ex = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL overrun e=%0d got p/b/d/o=%h exp=%h", e, got, ex);
            end
        end
        do_reset(trig, 4'b1111, 0);
        n_cmp++;
        if (overrun !== 4'b0000) begin
            n_bad++;
            $display("FAIL overrun_clear got=%b exp=0000", overrun);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got, ex;
        retrig_en = 1'b0; delay = '0; width = '0;
        do_reset(4'b0000, 4'b1111, 3);
        set_dw(0, 401, 79);
        clear_exp(); add_win(0, 0, 401, 79, -1); push_exp(20);
        for (int e = 0; e < 20; e++) begin
            if (e == 0) trig[0] = 1'b1;
            @(posedge clk1); #1;
            got = {pulse, busy, done, overrun};
            ex = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL rstmid_pre e=%0d got p/b/d/o=%h exp=%h", e, got, ex);
            end
        end
        rst_n = 1'b0;
        @(posedge clk1); #1;
        rst_n = 1'b1;
        got = {pulse, busy, done, overrun};
        n_cmp++;
        if (got !== 16'h0000) begin
            n_bad++;
            $display("FAIL rstmid_zero got=%h exp=0000", got);
        end
        // trig[0] stays high through reset release: one fresh rising event.
        clear_exp(); add_win(0, 0, 401, 79, -1); push_exp(490);
        for (int e = 0; e < 490; e++) begin
            @(posedge clk1); #1;
            got = {pulse, busy, done, overrun};
            ex = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL rstmid_post e=%0d got p/b/d/o=%h exp=%h", e, got, ex);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; trig = '0; edge_sel = '1; retrig_en = 1'b0;
        delay = '0; width = '0;
        @(negedge clk1);
        test_reset();
        test_long();
        test_zero();
        test_multi();
        test_retrig();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
